// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master
// Purpose  : CPU-side initiator for a word-wide data memory. Takes byte, half
//            and word load/store requests and issues word-aligned memory
//            cycles. Loads get lane extraction plus sign or zero extension.
//            Sub-word stores use a read-modify-write sequence. Misaligned,
//            illegal-size and out-of-range requests are rejected without
//            any memory cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS   = 512,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_r_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  // Captured request fields; only the low half of the store data is ever
  // needed after accept because word stores go straight into mem_wdata_q.
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic        req_err_d;
  logic [7:0]  ld_byte_d;
  logic [15:0] ld_half_d;
  logic [31:0] ld_data_d;
  logic [31:0] st_merge_d;

  // Request legality: alignment, size encoding and optional range limit.
  always_comb begin
    req_err_d = 1'b0;
    case (req_size_i)
      2'b00:   req_err_d = 1'b0;
      2'b01:   req_err_d = req_addr_i[0];
      2'b10:   req_err_d = |req_addr_i[1:0];
      default: req_err_d = 1'b1;
    endcase
    if (CHECK_RANGE && ({2'b00, req_addr_i[31:2]} >= MEM_WORDS)) begin
      req_err_d = 1'b1;
    end
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores,
  // both working on the word currently returned by memory.
  always_comb begin
    ld_byte_d  = mem_rdata_i[7:0];
    case (off_q)
      2'b00:   ld_byte_d = mem_rdata_i[7:0];
      2'b01:   ld_byte_d = mem_rdata_i[15:8];
      2'b10:   ld_byte_d = mem_rdata_i[23:16];
      default: ld_byte_d = mem_rdata_i[31:24];
    endcase
    ld_half_d  = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ld_data_d  = mem_rdata_i;
    st_merge_d = mem_rdata_i;
    case (size_q)
      2'b00: begin
        ld_data_d = {{24{ld_byte_d[7] & ~unsigned_q}}, ld_byte_d};
        case (off_q)
          2'b00:   st_merge_d[7:0]   = wdata_q[7:0];
          2'b01:   st_merge_d[15:8]  = wdata_q[7:0];
          2'b10:   st_merge_d[23:16] = wdata_q[7:0];
          default: st_merge_d[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        ld_data_d = {{16{ld_half_d[15] & ~unsigned_q}}, ld_half_d};
        if (off_q[1]) begin
          st_merge_d[31:16] = wdata_q;
        end else begin
          st_merge_d[15:0] = wdata_q;
        end
      end
      default: ;
    endcase
  end

  // Access sequencer: IDLE -> (RD) -> (WR) -> RESP -> IDLE, outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            size_q      <= req_size_i;
            unsigned_q  <= req_unsigned_i;
            off_q       <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i[15:0];
            if (req_err_d) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              mem_addr_q <= {req_addr_i[31:2], 2'b00};
              if (req_we_i && (req_size_i == 2'b10)) begin
                mem_wdata_q <= req_wdata_i;
                state_q     <= S_WR;
              end else begin
                state_q <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (we_q) begin
            mem_wdata_q <= st_merge_d;
            state_q     <= S_WR;
          end else begin
            resp_rdata_q <= ld_data_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes come straight from state so an async reset kills them at once.
  assign mem_r_o      = (state_q == S_RD);
  assign mem_wr_o     = (state_q == S_WR);
  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_master
// Purpose  : Directed self-checking bench for lsu_mem_master with a simple
//            word memory model attached to the master port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_r;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:511];

  int n_checks = 0;
  int n_err    = 0;

  lsu_mem_master #(
    .MEM_WORDS   (512),
    .CHECK_RANGE (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .mem_r_o        (mem_r),
    .mem_wr_o       (mem_wr),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge.
  assign mem_rdata = mem[mem_addr[10:2]];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[10:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobes must never overlap.
  always @(negedge clk) begin
    if (rst === 1'b0 && (mem_r & mem_wr)) check("rd_wr_overlap", {31'b0, mem_r & mem_wr}, 32'h0);
  end

  // One request: returns response data, error flag, latency from the accept
  // edge (0 on timeout) and the number of read/write strobe cycles seen.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nrd, output int nwr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    lat = 0; nrd = 0; nwr = 0; rdata = 32'hX; err = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_r)  nrd++;
      if (mem_wr) nwr++;
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nrd, nwr;
  logic [31:0] b2b_addr [0:3];
  logic [31:0] b2b_exp  [0:3];
  int          acc_cyc  [0:3];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[511] = 32'hCAFE_F00D;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_strobes", {30'b0, mem_r, mem_wr}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat, nrd, nwr);
    check("wst_lat", lat, 2); check("wst_err", {31'b0, er}, 0); check("wst_rdata", rd, 0);
    check("wst_nwr", nwr, 1); check("wst_nrd", nrd, 0);
    @(negedge clk);
    check("wst_mem", mem[4], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
    check("wld_data", rd, 32'hDEAD_BEEF); check("wld_lat", lat, 2);
    check("wld_err", {31'b0, er}, 0); check("wld_nrd", nrd, 1);

    // Byte store with junk in upper store bits
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAA_AA55, rd, er, lat, nrd, nwr);
    check("bst_lat", lat, 3); check("bst_nrd", nrd, 1); check("bst_nwr", nwr, 1);
    @(negedge clk);
    check("bst_mem", mem[4], 32'hDEAD_55EF);

    // Loads with extension
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat, nrd, nwr);
    check("bld13_s", rd, 32'hFFFF_FFDE);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat, nrd, nwr);
    check("bld13_u", rd, 32'h0000_00DE);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat, nrd, nwr);
    check("bld11_s", rd, 32'h0000_0055);
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
    check("bld10_s", rd, 32'hFFFF_FFEF);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat, nrd, nwr);
    check("hld12_s", rd, 32'hFFFF_DEAD);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
    check("hld10_u", rd, 32'h0000_55EF);

    // Half store to upper lane
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234, rd, er, lat, nrd, nwr);
    check("hst_lat", lat, 3);
    @(negedge clk);
    check("hst_mem", mem[4], 32'h1234_55EF);

    // Last in-range word
    do_req(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, rd, er, lat, nrd, nwr);
    check("wld_last", rd, 32'hCAFE_F00D); check("wld_last_err", {31'b0, er}, 0);

    // Rejected requests
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, er, lat, nrd, nwr);
    check("e_half_err", {31'b0, er}, 1); check("e_half_lat", lat, 1);
    check("e_half_mem", nrd + nwr, 0); check("e_half_rdata", rd, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h06, 32'h1357_9BDF, rd, er, lat, nrd, nwr);
    check("e_word_err", {31'b0, er}, 1); check("e_word_mem", nrd + nwr, 0);
    check("e_word_untouched", mem[1], 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, er, lat, nrd, nwr);
    check("e_size_err", {31'b0, er}, 1); check("e_size_mem", nrd + nwr, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, rd, er, lat, nrd, nwr);
    check("e_range_err", {31'b0, er}, 1); check("e_range_mem", nrd + nwr, 0);
    @(negedge clk);
    check("e_cleared", {31'b0, resp_err}, 0);

    // Back-to-back word loads with req_valid held high
    b2b_addr[0] = 32'h10;  b2b_exp[0] = 32'h1234_55EF;
    b2b_addr[1] = 32'h7FC; b2b_exp[1] = 32'hCAFE_F00D;
    b2b_addr[2] = 32'h0;   b2b_exp[2] = 32'h0;
    b2b_addr[3] = 32'h10;  b2b_exp[3] = 32'h1234_55EF;
    begin
      int n_acc, n_rsp;
      logic pend;
      n_acc = 0; n_rsp = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = b2b_addr[0];
      for (int cyc = 0; cyc < 40; cyc++) begin
        pend = req_valid & req_ready;
        if (resp_valid) begin
          if (n_rsp < 4) check("b2b_data", resp_rdata, b2b_exp[n_rsp]);
          n_rsp++;
        end
        @(posedge clk);
        #1;
        if (pend) begin
          acc_cyc[n_acc] = cyc;
          n_acc++;
          if (n_acc < 4) req_addr = b2b_addr[n_acc];
          else req_valid = 1'b0;
        end
        @(negedge clk);
        if (n_rsp == 4 && n_acc == 4 && cyc > acc_cyc[3] + 4) break;
      end
      check("b2b_accepts", n_acc, 4);
      check("b2b_resps", n_rsp, 4);
      if (n_acc == 4) begin
        check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 3);
        check("b2b_gap3", acc_cyc[3] - acc_cyc[2], 3);
      end
    end

    // Async reset in the middle of a word store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10;
    req_wdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    check("mid_wr_active", {31'b0, mem_wr}, 1);
    rst = 1'b1;
    #1;
    check("mid_wr_dropped", {31'b0, mem_wr}, 0);
    check("mid_wr_ready", {31'b0, req_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    check("mid_wr_mem", mem[4], 32'h1234_55EF);
    rst = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
    check("post_rst_load", rd, 32'h1234_55EF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
